// File: rtl/alu_reservation_station_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_reservation_station_if
//  Purpose  : Bundles the dispatcher->RS path, the ALU/LSB result broadcasts
//             and the RS->ALU issue port of the ALU reservation station.
//  Ports    : none (signal bundle only)
//             master modport : dispatcher / broadcast / control side
//             slave modport  : reservation station side
//  Revision : 1.0  initial release
// ============================================================================
interface alu_reservation_station_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
) ();
    // Control
    logic              rdy;
    logic              is_clear;

    // Dispatch
    logic              dispatch_en;
    logic [OP_W-1:0]   dis_opcode;
    logic [ROB_W-1:0]  dis_rob_id;
    logic [31:0]       dis_vi;
    logic [31:0]       dis_vj;
    logic [ROB_W-1:0]  dis_qi;
    logic [ROB_W-1:0]  dis_qj;
    logic              dis_oi;
    logic              dis_oj;
    logic [31:0]       dis_imm;
    logic [31:0]       dis_pc;
    logic              rs_full;

    // Result broadcasts
    logic              alu_ok;
    logic [31:0]       alu_val;
    logic [ROB_W-1:0]  alu_rob_id;
    logic              lsb_ok;
    logic [31:0]       lsb_val;
    logic [ROB_W-1:0]  lsb_rob_id;

    // Issue to ALU
    logic              alu_en;
    logic [OP_W-1:0]   alu_opcode;
    logic [31:0]       alu_v1;
    logic [31:0]       alu_v2;
    logic [31:0]       alu_imm;
    logic [31:0]       alu_pc;
    logic [ROB_W-1:0]  alu_rob_id_o;

    modport master (
        output rdy, is_clear,
        output dispatch_en, dis_opcode, dis_rob_id, dis_vi, dis_vj,
        output dis_qi, dis_qj, dis_oi, dis_oj, dis_imm, dis_pc,
        input  rs_full,
        output alu_ok, alu_val, alu_rob_id, lsb_ok, lsb_val, lsb_rob_id,
        input  alu_en, alu_opcode, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id_o
    );

    modport slave (
        input  rdy, is_clear,
        input  dispatch_en, dis_opcode, dis_rob_id, dis_vi, dis_vj,
        input  dis_qi, dis_qj, dis_oi, dis_oj, dis_imm, dis_pc,
        output rs_full,
        input  alu_ok, alu_val, alu_rob_id, lsb_ok, lsb_val, lsb_rob_id,
        output alu_en, alu_opcode, alu_v1, alu_v2, alu_imm, alu_pc, alu_rob_id_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : alu_reservation_station
//  Purpose  : Tomasulo reservation station for ALU/branch ops. Accepts one
//             dispatched op per cycle, wakes pending operands from the ALU
//             and LSB result broadcasts, and issues the lowest-index ready
//             entry to the ALU once per cycle.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - alu_reservation_station_if.slave (control, dispatch,
//                    broadcasts, rs_full, registered issue outputs)
//  Revision : 1.0  initial release
// ============================================================================
module alu_reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    alu_reservation_station_if.slave  bus
);

    localparam int c_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_o1;
    logic [RS_SIZE-1:0] r_o2;
    logic [OP_W-1:0]    r_opcode [RS_SIZE];
    logic [ROB_W-1:0]   r_rob_id [RS_SIZE];
    logic [ROB_W-1:0]   r_q1     [RS_SIZE];
    logic [ROB_W-1:0]   r_q2     [RS_SIZE];
    logic [31:0]        r_v1     [RS_SIZE];
    logic [31:0]        r_v2     [RS_SIZE];
    logic [31:0]        r_imm    [RS_SIZE];
    logic [31:0]        r_pc     [RS_SIZE];

    // Issue output registers
    logic               r_alu_en;
    logic [OP_W-1:0]    r_alu_opcode;
    logic [31:0]        r_alu_v1;
    logic [31:0]        r_alu_v2;
    logic [31:0]        r_alu_imm;
    logic [31:0]        r_alu_pc;
    logic [ROB_W-1:0]   r_alu_rob_id;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               w_full;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_sel_found;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic [31:0]        w_dis_v1;
    logic [31:0]        w_dis_v2;
    logic               w_dis_o1;
    logic               w_dis_o2;

    assign w_full = &r_busy;

    // Lowest-index free slot and lowest-index ready entry. Scanning from
    // the top down lets the last hit (lowest index) win.
    always_comb begin
        w_free_idx  = '0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = c_IDX_W'(i);
            end
            if (r_busy[i] && r_o1[i] && r_o2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IDX_W'(i);
            end
        end
    end

    // Dispatch bypass: a producer that broadcasts in the same cycle the
    // consumer is dispatched would otherwise be missed forever.
    always_comb begin
        w_dis_v1 = bus.dis_vi;
        w_dis_o1 = bus.dis_oi;
        w_dis_v2 = bus.dis_vj;
        w_dis_o2 = bus.dis_oj;
        if (!bus.dis_oi) begin
            if (bus.alu_ok && (bus.dis_qi == bus.alu_rob_id)) begin
                w_dis_v1 = bus.alu_val;
                w_dis_o1 = 1'b1;
            end else if (bus.lsb_ok && (bus.dis_qi == bus.lsb_rob_id)) begin
                w_dis_v1 = bus.lsb_val;
                w_dis_o1 = 1'b1;
            end
        end
        if (!bus.dis_oj) begin
            if (bus.alu_ok && (bus.dis_qj == bus.alu_rob_id)) begin
                w_dis_v2 = bus.alu_val;
                w_dis_o2 = 1'b1;
            end else if (bus.lsb_ok && (bus.dis_qj == bus.lsb_rob_id)) begin
                w_dis_v2 = bus.lsb_val;
                w_dis_o2 = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_o1         <= '0;
            r_o2         <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_opcode[i] <= '0;
                r_rob_id[i] <= '0;
                r_q1[i]     <= '0;
                r_q2[i]     <= '0;
                r_v1[i]     <= '0;
                r_v2[i]     <= '0;
                r_imm[i]    <= '0;
                r_pc[i]     <= '0;
            end
            r_alu_en     <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_v1     <= '0;
            r_alu_v2     <= '0;
            r_alu_imm    <= '0;
            r_alu_pc     <= '0;
            r_alu_rob_id <= '0;
        end else if (bus.is_clear) begin
            // Flush: the same-cycle dispatch is discarded with everything else.
            r_busy   <= '0;
            r_alu_en <= 1'b0;
        end else if (bus.rdy) begin
            // Wakeup from broadcasts. Only takes effect on the stored flags,
            // so a woken entry is first selectable on the following cycle.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && !r_o1[i]) begin
                    if (bus.alu_ok && (r_q1[i] == bus.alu_rob_id)) begin
                        r_v1[i] <= bus.alu_val;
                        r_o1[i] <= 1'b1;
                    end else if (bus.lsb_ok && (r_q1[i] == bus.lsb_rob_id)) begin
                        r_v1[i] <= bus.lsb_val;
                        r_o1[i] <= 1'b1;
                    end
                end
                if (r_busy[i] && !r_o2[i]) begin
                    if (bus.alu_ok && (r_q2[i] == bus.alu_rob_id)) begin
                        r_v2[i] <= bus.alu_val;
                        r_o2[i] <= 1'b1;
                    end else if (bus.lsb_ok && (r_q2[i] == bus.lsb_rob_id)) begin
                        r_v2[i] <= bus.lsb_val;
                        r_o2[i] <= 1'b1;
                    end
                end
            end

            // Issue
            if (w_sel_found) begin
                r_alu_en            <= 1'b1;
                r_alu_opcode        <= r_opcode[w_sel_idx];
                r_alu_v1            <= r_v1[w_sel_idx];
                r_alu_v2            <= r_v2[w_sel_idx];
                r_alu_imm           <= r_imm[w_sel_idx];
                r_alu_pc            <= r_pc[w_sel_idx];
                r_alu_rob_id        <= r_rob_id[w_sel_idx];
                r_busy[w_sel_idx]   <= 1'b0;
            end else begin
                r_alu_en <= 1'b0;
            end

            // Allocation uses the pre-edge busy vector, so the free slot can
            // never be the one issuing at this same edge.
            if (bus.dispatch_en && !w_full) begin
                r_busy[w_free_idx]   <= 1'b1;
                r_opcode[w_free_idx] <= bus.dis_opcode;
                r_rob_id[w_free_idx] <= bus.dis_rob_id;
                r_q1[w_free_idx]     <= bus.dis_qi;
                r_q2[w_free_idx]     <= bus.dis_qj;
                r_v1[w_free_idx]     <= w_dis_v1;
                r_v2[w_free_idx]     <= w_dis_v2;
                r_o1[w_free_idx]     <= w_dis_o1;
                r_o2[w_free_idx]     <= w_dis_o2;
                r_imm[w_free_idx]    <= bus.dis_imm;
                r_pc[w_free_idx]     <= bus.dis_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rs_full      = w_full;
    assign bus.alu_en       = r_alu_en;
    assign bus.alu_opcode   = r_alu_opcode;
    assign bus.alu_v1       = r_alu_v1;
    assign bus.alu_v2       = r_alu_v2;
    assign bus.alu_imm      = r_alu_imm;
    assign bus.alu_pc       = r_alu_pc;
    assign bus.alu_rob_id_o = r_alu_rob_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_reservation_station
//  Purpose  : Self-checking bench for alu_reservation_station. Issued ops
//             are compared in order against a scoreboard queue filled as
//             stimulus is driven; timing and rs_full are checked inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_reservation_station;

    localparam int c_ROB_W = 4;
    localparam int c_OP_W  = 6;

    logic clk;
    logic rst;

    alu_reservation_station_if #(.ROB_W(c_ROB_W), .OP_W(c_OP_W)) bus ();

    alu_reservation_station #(.RS_SIZE(8), .ROB_W(c_ROB_W), .OP_W(c_OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [c_OP_W-1:0]  op;
        logic [c_ROB_W-1:0] rob;
        logic [31:0]        v1;
        logic [31:0]        v2;
        logic [31:0]        imm;
        logic [31:0]        pc;
    } exp_t;

    typedef struct {
        logic [c_OP_W-1:0]  op;
        logic [c_ROB_W-1:0] rob;
        logic [31:0]        vi, vj;
        logic               oi, oj;
        logic [c_ROB_W-1:0] qi, qj;
        logic [31:0]        imm, pc;
        logic               aok;
        logic [c_ROB_W-1:0] atag;
        logic [31:0]        aval;
        logic               lok;
        logic [c_ROB_W-1:0] ltag;
        logic [31:0]        lval;
        logic [31:0]        ev1, ev2;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic exp_t mkexp(logic [c_OP_W-1:0] op, logic [c_ROB_W-1:0] rob,
                                   logic [31:0] v1, logic [31:0] v2,
                                   logic [31:0] imm, logic [31:0] pc);
        exp_t e;
        e.op = op; e.rob = rob; e.v1 = v1; e.v2 = v2; e.imm = imm; e.pc = pc;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.dispatch_en = 1'b0;
        bus.alu_ok      = 1'b0;
        bus.lsb_ok      = 1'b0;
        bus.is_clear    = 1'b0;
    endtask

    task automatic drive_dis(logic [c_OP_W-1:0] op, logic [c_ROB_W-1:0] rob,
                             logic [31:0] vi, logic [31:0] vj, logic oi, logic oj,
                             logic [c_ROB_W-1:0] qi, logic [c_ROB_W-1:0] qj,
                             logic [31:0] imm, logic [31:0] pc);
        bus.dispatch_en = 1'b1;
        bus.dis_opcode  = op;
        bus.dis_rob_id  = rob;
        bus.dis_vi      = vi;
        bus.dis_vj      = vj;
        bus.dis_oi      = oi;
        bus.dis_oj      = oj;
        bus.dis_qi      = qi;
        bus.dis_qj      = qj;
        bus.dis_imm     = imm;
        bus.dis_pc      = pc;
    endtask

    task automatic bc_alu(logic [c_ROB_W-1:0] tag, logic [31:0] val);
        bus.alu_ok = 1'b1; bus.alu_rob_id = tag; bus.alu_val = val;
    endtask

    task automatic bc_lsb(logic [c_ROB_W-1:0] tag, logic [31:0] val);
        bus.lsb_ok = 1'b1; bus.lsb_rob_id = tag; bus.lsb_val = val;
    endtask

    // Scoreboard: every issue strobe must match the oldest expected op.
    always @(negedge clk) begin
        if (bus.alu_en === 1'b1) begin
            exp_t got;
            exp_t e;
            got = mkexp(bus.alu_opcode, bus.alu_rob_id_o, bus.alu_v1, bus.alu_v2,
                        bus.alu_imm, bus.alu_pc);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got rob=%0h v1=%0h v2=%0h expected no issue at %0t",
                         got.rob, got.v1, got.v2, $time);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL issue: got op=%0h rob=%0h v1=%0h v2=%0h imm=%0h pc=%0h expected op=%0h rob=%0h v1=%0h v2=%0h imm=%0h pc=%0h at %0t",
                             got.op, got.rob, got.v1, got.v2, got.imm, got.pc,
                             e.op, e.rob, e.v1, e.v2, e.imm, e.pc, $time);
                end
            end
        end
    end

    function automatic vec_t mk(logic [c_OP_W-1:0] op, logic [c_ROB_W-1:0] rob,
                                logic [31:0] vi, logic [31:0] vj, logic oi, logic oj,
                                logic [c_ROB_W-1:0] qi, logic [c_ROB_W-1:0] qj,
                                logic [31:0] imm, logic [31:0] pc,
                                logic aok, logic [c_ROB_W-1:0] atag, logic [31:0] aval,
                                logic lok, logic [c_ROB_W-1:0] ltag, logic [31:0] lval,
                                logic [31:0] ev1, logic [31:0] ev2);
        vec_t v;
        v.op = op; v.rob = rob; v.vi = vi; v.vj = vj; v.oi = oi; v.oj = oj;
        v.qi = qi; v.qj = qj; v.imm = imm; v.pc = pc;
        v.aok = aok; v.atag = atag; v.aval = aval;
        v.lok = lok; v.ltag = ltag; v.lval = lval;
        v.ev1 = ev1; v.ev2 = ev2;
        return v;
    endfunction

    vec_t tbl [6];

    initial begin
        // Back-to-back dispatches; each row ready at dispatch, directly or
        // through the same-cycle broadcast bypass.
        tbl[0] = mk(6'h02, 4'h1, 32'hDEAD_BEEF, 32'h1, 1, 1, 0, 0, 32'h10, 32'h100,
                    0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h1);
        tbl[1] = mk(6'h03, 4'h4, 32'h1, 32'h0, 1, 0, 0, 4'h4, 32'h0, 32'h104,
                    0, 0, 0, 1, 4'h4, 32'hAB, 32'h1, 32'hAB);
        tbl[2] = mk(6'h04, 4'h5, 32'h999, 32'h22, 0, 1, 4'h7, 0, 32'h4, 32'h108,
                    1, 4'h7, 32'h77, 0, 0, 0, 32'h77, 32'h22);
        tbl[3] = mk(6'h05, 4'h6, 32'h0, 32'h0, 0, 0, 4'h9, 4'hA, 32'h8, 32'h10C,
                    1, 4'h9, 32'h90, 1, 4'hA, 32'hA0, 32'h90, 32'hA0);
        tbl[4] = mk(6'h06, 4'h7, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 32'hFFFF_F000, 32'hFFFF_FFFC,
                    0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0);
        tbl[5] = mk(6'h3F, 4'hF, 32'h0, 32'h0, 0, 1, 4'h3, 0, 32'h1, 32'h110,
                    0, 0, 0, 1, 4'h3, 32'h1234_5678, 32'h1234_5678, 32'h0);

        rst = 1'b1;
        bus.rdy = 1'b1;
        idle();
        drive_dis(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.dispatch_en = 1'b0;
        bus.alu_rob_id = '0; bus.alu_val = '0;
        bus.lsb_rob_id = '0; bus.lsb_val = '0;
        repeat (3) step();

        // Reset state
        chk("reset_alu_en", 32'(bus.alu_en), 0);
        chk("reset_rs_full", 32'(bus.rs_full), 0);
        chk("reset_alu_v1", bus.alu_v1, 0);
        chk("reset_alu_rob", 32'(bus.alu_rob_id_o), 0);
        rst = 1'b0;

        // Ready dispatch -> single issue pulse one cycle later
        drive_dis(6'h01, 4'h3, 32'd5, 32'd7, 1, 1, 0, 0, 32'h0, 32'h40);
        sb.push_back(mkexp(6'h01, 4'h3, 32'd5, 32'd7, 32'h0, 32'h40));
        step(); idle();
        chk("t1_no_issue_at_dispatch", 32'(bus.alu_en), 0);
        step();
        chk("t1_issue", 32'(bus.alu_en), 1);
        step();
        chk("t1_single_pulse", 32'(bus.alu_en), 0);

        // Table vectors, one dispatch per cycle
        for (int i = 0; i < 6; i++) begin
            idle();
            drive_dis(tbl[i].op, tbl[i].rob, tbl[i].vi, tbl[i].vj, tbl[i].oi, tbl[i].oj,
                      tbl[i].qi, tbl[i].qj, tbl[i].imm, tbl[i].pc);
            if (tbl[i].aok) bc_alu(tbl[i].atag, tbl[i].aval);
            if (tbl[i].lok) bc_lsb(tbl[i].ltag, tbl[i].lval);
            sb.push_back(mkexp(tbl[i].op, tbl[i].rob, tbl[i].ev1, tbl[i].ev2,
                               tbl[i].imm, tbl[i].pc));
            step();
            if (i > 0) chk("tbl_stream_issue", 32'(bus.alu_en), 1);
        end
        idle();
        step();
        chk("tbl_last_issue", 32'(bus.alu_en), 1);
        step();
        chk("tbl_drained", 32'(bus.alu_en), 0);

        // Wakeup via ALU broadcast after 3 idle cycles
        drive_dis(6'h07, 4'h6, 32'h0, 32'h9, 0, 1, 4'h2, 0, 32'h8, 32'h80);
        sb.push_back(mkexp(6'h07, 4'h6, 32'h10, 32'h9, 32'h8, 32'h80));
        step(); idle();
        chk("t2_wait0", 32'(bus.alu_en), 0);
        step();
        chk("t2_wait1", 32'(bus.alu_en), 0);
        step();
        chk("t2_wait2", 32'(bus.alu_en), 0);
        bc_alu(4'h2, 32'h10);
        step(); idle();
        chk("t2_not_same_cycle", 32'(bus.alu_en), 0);
        step();
        chk("t2_issue", 32'(bus.alu_en), 1);
        step();
        chk("t2_done", 32'(bus.alu_en), 0);

        // Fill all 8 slots with ops waiting on tags 0..7
        for (int i = 0; i < 8; i++) begin
            idle();
            drive_dis(6'h01, 4'(i), 32'h0, 32'h100 + 32'(i), 0, 1, 4'(i), 0, 32'h0, 32'(i * 4));
            step();
            chk("t4_rs_full_fill", 32'(bus.rs_full), (i == 7) ? 1 : 0);
        end
        idle();
        drive_dis(6'h02, 4'hF, 32'h1, 32'h1, 1, 1, 0, 0, 32'h0, 32'h0);
        step(); idle();
        chk("t4_drop_full", 32'(bus.rs_full), 1);
        chk("t4_drop_no_issue", 32'(bus.alu_en), 0);
        bc_alu(4'h5, 32'h55);
        sb.push_back(mkexp(6'h01, 4'h5, 32'h55, 32'h105, 32'h0, 32'h14));
        step(); idle();
        chk("t4_full_after_wake", 32'(bus.rs_full), 1);
        step();
        chk("t4_issue_slot5", 32'(bus.alu_en), 1);
        chk("t4_full_drops", 32'(bus.rs_full), 0);
        drive_dis(6'h01, 4'h8, 32'h0, 32'h200, 0, 1, 4'h8, 0, 32'h0, 32'h80);
        step(); idle();
        chk("t4_refill_full", 32'(bus.rs_full), 1);
        // Drain: index order reveals that the refill landed in slot 5
        sb.push_back(mkexp(6'h01, 4'h0, 32'h50, 32'h100, 32'h0, 32'h0));
        sb.push_back(mkexp(6'h01, 4'h1, 32'h51, 32'h101, 32'h0, 32'h4));
        sb.push_back(mkexp(6'h01, 4'h2, 32'h52, 32'h102, 32'h0, 32'h8));
        sb.push_back(mkexp(6'h01, 4'h3, 32'h53, 32'h103, 32'h0, 32'hC));
        sb.push_back(mkexp(6'h01, 4'h4, 32'h54, 32'h104, 32'h0, 32'h10));
        sb.push_back(mkexp(6'h01, 4'h8, 32'h58, 32'h200, 32'h0, 32'h80));
        sb.push_back(mkexp(6'h01, 4'h6, 32'h56, 32'h106, 32'h0, 32'h18));
        sb.push_back(mkexp(6'h01, 4'h7, 32'h57, 32'h107, 32'h0, 32'h1C));
        bc_alu(4'h0, 32'h50); bc_lsb(4'h1, 32'h51); step();
        bc_alu(4'h2, 32'h52); bc_lsb(4'h3, 32'h53); step();
        bc_alu(4'h4, 32'h54); bc_lsb(4'h8, 32'h58); step();
        bc_alu(4'h6, 32'h56); bc_lsb(4'h7, 32'h57); step();
        idle();
        repeat (8) step();
        chk("t4_empty", 32'(bus.rs_full), 0);
        chk("t4_quiet", 32'(bus.alu_en), 0);

        // Flush with ready entries queued
        for (int i = 0; i < 4; i++) begin
            drive_dis(6'h0A, 4'(i), 32'h0, 32'h300 + 32'(i), 0, 1, 4'h9, 0, 32'h0, 32'h200);
            step();
        end
        idle();
        bc_alu(4'h9, 32'h9);
        sb.push_back(mkexp(6'h0A, 4'h0, 32'h9, 32'h300, 32'h0, 32'h200));
        step(); idle();
        step();
        chk("t5_first_issue", 32'(bus.alu_en), 1);
        bus.is_clear = 1'b1;
        drive_dis(6'h0B, 4'hE, 32'h1, 32'h2, 1, 1, 0, 0, 32'h0, 32'h0);
        step(); idle();
        chk("t5_clear_alu_en", 32'(bus.alu_en), 0);
        chk("t5_clear_rs_full", 32'(bus.rs_full), 0);
        bc_alu(4'h9, 32'h9);
        step(); idle();
        repeat (3) step();
        chk("t5_no_late_issue", 32'(bus.alu_en), 0);

        // rdy=0 freeze with a ready entry and a broadcast
        drive_dis(6'h09, 4'hC, 32'h0, 32'h33, 0, 1, 4'h6, 0, 32'h0, 32'h60);
        step();
        drive_dis(6'h0A, 4'hB, 32'h11, 32'h22, 1, 1, 0, 0, 32'h5, 32'h64);
        sb.push_back(mkexp(6'h0A, 4'hB, 32'h11, 32'h22, 32'h5, 32'h64));
        step(); idle();
        bus.rdy = 1'b0;
        step();
        chk("t6_frozen0", 32'(bus.alu_en), 0);
        bc_alu(4'h6, 32'h66);
        step(); idle();
        chk("t6_frozen1", 32'(bus.alu_en), 0);
        step();
        chk("t6_frozen2", 32'(bus.alu_en), 0);
        chk("t6_frozen_full", 32'(bus.rs_full), 0);
        bus.rdy = 1'b1;
        step();
        chk("t6_resume_issue", 32'(bus.alu_en), 1);
        step();
        chk("t6_broadcast_ignored", 32'(bus.alu_en), 0);
        bc_alu(4'h6, 32'h66);
        sb.push_back(mkexp(6'h09, 4'hC, 32'h66, 32'h33, 32'h0, 32'h60));
        step(); idle();
        chk("t6_wake_latency", 32'(bus.alu_en), 0);
        step();
        chk("t6_wake_issue", 32'(bus.alu_en), 1);
        step();
        chk("t6_done", 32'(bus.alu_en), 0);

        repeat (2) step();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
